traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter YMIN, default 2, minimum legal yellow dwell in clk cycles.
REQ-002 SHALL have parameter GMAX, default 16, maximum legal green dwell in clk cycles (2..30).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port light_M1  input  3  main road 1 lamp; 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-006 SHALL have port light_M2  input  3  main road 2 lamp; same encoding.
REQ-007 SHALL have port light_MT  input  3  main turn lamp; same encoding.
REQ-008 SHALL have port light_S  input  3  side road lamp; same encoding.
REQ-009 SHALL have port fault  output  1  sticky violation flag.
REQ-010 SHALL have port fault_code  output  3  code of first violation.
REQ-011 SHALL have port fault_src  output  2  approach of first violation: M1=0, M2=1, MT=2, S=3.
REQ-012 SHALL have port fault_cnt  output  4  count of violating cycles, saturating at 15.

Function
REQ-013 SHALL sample all four lamp buses every cycle and evaluate the checks in REQ-014..REQ-018 on the sampled values.
REQ-014 SHALL flag code 1 (encoding) when any bus is not one-hot (000, or 2+ bits set).
REQ-015 SHALL flag code 2 (conflict) when S is non-red while any of M1/M2/MT is non-red, or MT is non-red while M2 is non-red; src = 3 if S is involved, else 2.
REQ-016 SHALL flag code 3 (sequence) on any approach change other than R->G, G->Y, Y->R; holding a colour is legal.
REQ-017 SHALL flag code 4 (short yellow) on a Y->R change when that approach's yellow dwell < YMIN.
REQ-018 SHALL flag code 5 (long green) in the cycle an approach's green dwell reaches GMAX+1.
REQ-019 SHALL keep a 5-bit dwell counter per approach: set to 1 on a colour change, otherwise incremented, saturating at 31.
REQ-020 SHALL suppress codes 3 and 4 on the first sample after reset, since no previous sample exists; codes 1, 2 and 5 stay active.
REQ-021 SHALL skip codes 3, 4 and 5 for an approach whose current or previous sample is badly encoded, and SHALL restart its dwell at 1 once encoding is valid again.
REQ-022 SHALL register outputs: a violation sampled at edge N is visible on fault, fault_code and fault_src after edge N+1.
REQ-023 SHALL latch fault_code and fault_src only on the first violation; fault stays high until reset.
REQ-024 SHALL resolve simultaneous violations by lowest code, then by lowest approach index.
REQ-025 SHALL increment fault_cnt once per cycle that has at least one violation, saturating at 15.

Reset
REQ-026 SHALL drive fault=0, fault_code=0, fault_src=0 and fault_cnt=0 during reset and in the first cycle after it.
REQ-027 SHALL clear all dwell counters and previous-sample-valid on reset, including a reset applied mid-fault.

Structure
REQ-028 SHALL take from shared package traffic_pkg: the colour encodings, approach indices and fault code constants.
REQ-029 SHALL use sub-module light_channel_checker, instanced four times, for encoding, sequence and dwell checks; the conflict check and first-fault capture stay at top level.

Verification
REQ-030 SHALL test legal cycle M1 R->G(16 cycles)->Y(2)->R -> fault=0, fault_cnt=0.
REQ-031 SHALL test S=001 with M1=001 -> one cycle later fault=1, fault_code=2, fault_src=3.
REQ-032 SHALL test MT G->R directly -> fault_code=3, fault_src=2.
REQ-033 SHALL test M2 yellow for 1 cycle, then red -> fault_code=4, fault_src=1.
REQ-034 SHALL test M1=000 and S=011 in the same cycle -> fault_code=1, fault_src=0; hold 20 cycles -> fault_cnt=15.
REQ-035 SHALL test rst=1 for one cycle while fault=1 -> all outputs 0; first sample after reset with M1=Y -> no code 3.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, approach indices and fault codes for the traffic light monitor.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam int NUM_APP = 4;

  localparam logic [1:0] APP_M1 = 2'd0;
  localparam logic [1:0] APP_M2 = 2'd1;
  localparam logic [1:0] APP_MT = 2'd2;
  localparam logic [1:0] APP_S  = 2'd3;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_ENCODING  = 3'd1;
  localparam logic [2:0] FC_CONFLICT  = 3'd2;
  localparam logic [2:0] FC_SEQUENCE  = 3'd3;
  localparam logic [2:0] FC_SHORT_YEL = 3'd4;
  localparam logic [2:0] FC_LONG_GRN  = 3'd5;

  localparam logic [4:0] DWELL_MAX = 5'd31;
  localparam logic [3:0] CNT_MAX   = 4'd15;

  function automatic logic lamp_ok(input logic [2:0] v);
    return (v == LAMP_RED) || (v == LAMP_YEL) || (v == LAMP_GRN);
  endfunction

  // Holding a colour or advancing R->G->Y->R is the only legal motion.
  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (prev == cur) ||
           (prev == LAMP_RED && cur == LAMP_GRN) ||
           (prev == LAMP_GRN && cur == LAMP_YEL) ||
           (prev == LAMP_YEL && cur == LAMP_RED);
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_APP - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/light_channel_checker.sv
// Per-approach checker: samples one lamp bus and flags encoding, sequence and dwell violations.
module light_channel_checker
  import traffic_pkg::*;
#(
  parameter int YMIN = 2,
  parameter int GMAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lamp,
  output logic [2:0] cur,
  output logic       cur_vld,
  output logic       enc_err,
  output logic       seq_err,
  output logic       short_yel,
  output logic       long_grn
);

  localparam logic [4:0] YMIN_W   = 5'(YMIN);
  localparam logic [4:0] GRN_TRIP = 5'(GMAX + 1);

  logic [2:0] prev;
  logic       prev_vld;
  logic [4:0] dwell;
  logic [4:0] prev_dwell;
  logic       cur_ok;
  logic       prev_ok;
  logic       timed;

  assign cur_ok  = lamp_ok(cur);
  assign prev_ok = lamp_ok(prev);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= 3'b000;
      prev       <= 3'b000;
      cur_vld    <= 1'b0;
      prev_vld   <= 1'b0;
      dwell      <= 5'd0;
      prev_dwell <= 5'd0;
    end else begin
      cur        <= lamp;
      prev       <= cur;
      cur_vld    <= 1'b1;
      prev_vld   <= cur_vld;
      prev_dwell <= dwell;
      // A bad sample on either side breaks the dwell history, so timing restarts.
      if (!cur_vld || !cur_ok || !lamp_ok(lamp) || lamp != cur) begin
        dwell <= 5'd1;
      end else if (dwell != DWELL_MAX) begin
        dwell <= dwell + 5'd1;
      end
    end
  end

  assign timed     = cur_vld && cur_ok && (!prev_vld || prev_ok);
  assign enc_err   = cur_vld && !cur_ok;
  assign seq_err   = timed && prev_vld && !legal_step(prev, cur);
  assign short_yel = timed && prev_vld && (prev == LAMP_YEL) && (cur == LAMP_RED) &&
                     (prev_dwell < YMIN_W);
  assign long_grn  = timed && (cur == LAMP_GRN) && (dwell == GRN_TRIP);

endmodule

// File: rtl/traffic_light_monitor.sv
// Intersection lamp monitor: per-approach checks, cross-approach conflict check, first-fault capture.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int YMIN = 2,
  parameter int GMAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_src,
  output logic [3:0] fault_cnt
);

  logic [2:0] lamp [NUM_APP];
  logic [2:0] cur  [NUM_APP];
  logic [3:0] cur_vld;
  logic [3:0] enc_err;
  logic [3:0] seq_err;
  logic [3:0] short_yel;
  logic [3:0] long_grn;

  assign lamp[APP_M1] = light_M1;
  assign lamp[APP_M2] = light_M2;
  assign lamp[APP_MT] = light_MT;
  assign lamp[APP_S]  = light_S;

  for (genvar g = 0; g < NUM_APP; g++) begin : g_chan
    light_channel_checker #(
      .YMIN(YMIN),
      .GMAX(GMAX)
    ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .lamp     (lamp[g]),
      .cur      (cur[g]),
      .cur_vld  (cur_vld[g]),
      .enc_err  (enc_err[g]),
      .seq_err  (seq_err[g]),
      .short_yel(short_yel[g]),
      .long_grn (long_grn[g])
    );
  end

  logic       samp_vld;
  logic       s_conf;
  logic       mt_conf;
  logic       viol;
  logic [2:0] viol_code;
  logic [1:0] viol_src;

  assign samp_vld = &cur_vld;

  // A badly encoded bus counts as non-red for conflict purposes.
  assign s_conf  = (cur[APP_S] != LAMP_RED) &&
                   ((cur[APP_M1] != LAMP_RED) || (cur[APP_M2] != LAMP_RED) ||
                    (cur[APP_MT] != LAMP_RED));
  assign mt_conf = (cur[APP_MT] != LAMP_RED) && (cur[APP_M2] != LAMP_RED);

  always_comb begin
    viol      = 1'b0;
    viol_code = FC_NONE;
    viol_src  = APP_M1;
    if (|enc_err) begin
      viol      = 1'b1;
      viol_code = FC_ENCODING;
      viol_src  = lowest_set(enc_err);
    end else if (samp_vld && (s_conf || mt_conf)) begin
      viol      = 1'b1;
      viol_code = FC_CONFLICT;
      viol_src  = s_conf ? APP_S : APP_MT;
    end else if (|seq_err) begin
      viol      = 1'b1;
      viol_code = FC_SEQUENCE;
      viol_src  = lowest_set(seq_err);
    end else if (|short_yel) begin
      viol      = 1'b1;
      viol_code = FC_SHORT_YEL;
      viol_src  = lowest_set(short_yel);
    end else if (|long_grn) begin
      viol      = 1'b1;
      viol_code = FC_LONG_GRN;
      viol_src  = lowest_set(long_grn);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      fault_src  <= APP_M1;
      fault_cnt  <= 4'd0;
    end else if (viol) begin
      if (!fault) begin
        fault      <= 1'b1;
        fault_code <= viol_code;
        fault_src  <= viol_src;
      end
      if (fault_cnt != CNT_MAX) fault_cnt <= fault_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: table of single-fault scenarios plus multi-cycle sequences.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [11:0] ALLR = {R, R, R, R};

  logic       clk;
  logic       rst;
  logic [2:0] m1, m2, mt, s;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_src;
  logic [3:0] fault_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_light_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .light_M1  (m1),
    .light_M2  (m2),
    .light_MT  (mt),
    .light_S   (s),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_src (fault_src),
    .fault_cnt (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pre;   // {M1, M2, MT, S}, held three cycles
    logic [11:0] mid;   // one cycle
    logic [11:0] trig;  // violating pattern
    int          code;
    int          src;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic [11:0] v);
    {m1, m2, mt, s} = v;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_lamps(ALLR);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ALLR,             ALLR,             {G, R, R, G},           2, 3};
    vecs[1] = '{{R, R, G, R},     {R, R, G, R},     ALLR,                   3, 2};
    vecs[2] = '{{R, G, R, R},     {R, Y, R, R},     ALLR,                   4, 1};
    vecs[3] = '{ALLR,             ALLR,             {3'b000, R, R, 3'b011}, 1, 0};
    vecs[4] = '{ALLR,             ALLR,             {R, G, G, R},           2, 2};
    vecs[5] = '{ALLR,             ALLR,             {Y, R, R, R},           3, 0};
    vecs[6] = '{{R, G, R, R},     {R, G, R, R},     {R, R, Y, R},           3, 1};
    vecs[7] = '{ALLR,             ALLR,             {R, R, 3'b110, 3'b000}, 1, 2};

    rst = 1'b1;
    set_lamps(ALLR);
    tick();
    check("reset_fault", int'(fault), 0);
    check("reset_code", int'(fault_code), 0);
    check("reset_cnt", int'(fault_cnt), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      set_lamps(vecs[i].pre);
      for (int k = 0; k < 3; k++) tick();
      set_lamps(vecs[i].mid);
      tick();
      set_lamps(vecs[i].trig);
      tick();
      check($sformatf("vec%0d_pre_clean", i), int'(fault), 0);
      tick();
      check($sformatf("vec%0d_fault", i), int'(fault), 1);
      check($sformatf("vec%0d_code", i), int'(fault_code), vecs[i].code);
      check($sformatf("vec%0d_src", i), int'(fault_src), vecs[i].src);
      check($sformatf("vec%0d_cnt", i), int'(fault_cnt), 1);
    end

    // Legal M1 cycle with green at exactly GMAX and yellow at exactly YMIN.
    do_reset();
    tick();
    tick();
    m1 = G;
    for (int k = 0; k < 16; k++) tick();
    m1 = Y;
    tick();
    tick();
    m1 = R;
    for (int k = 0; k < 3; k++) tick();
    check("legal_fault", int'(fault), 0);
    check("legal_cnt", int'(fault_cnt), 0);

    // Green held one cycle past GMAX.
    do_reset();
    tick();
    m1 = G;
    for (int k = 0; k < 17; k++) tick();
    check("green16_clean", int'(fault), 0);
    tick();
    check("long_green_fault", int'(fault), 1);
    check("long_green_code", int'(fault_code), 5);
    check("long_green_src", int'(fault_src), 0);
    check("long_green_cnt", int'(fault_cnt), 1);
    tick();
    check("long_green_once", int'(fault_cnt), 1);

    // Bad encoding suppresses the following sequence check and restarts dwell.
    do_reset();
    tick();
    m1 = 3'b000;
    tick();
    m1 = Y;
    tick();
    m1 = R;
    tick();
    check("recover_skip_seq", int'(fault_cnt), 1);
    tick();
    check("recover_short_yel", int'(fault_cnt), 2);
    check("recover_code", int'(fault_code), 1);

    // Simultaneous encoding errors held long enough to saturate the counter.
    do_reset();
    tick();
    tick();
    m1 = 3'b000;
    s  = 3'b011;
    tick();
    tick();
    check("enc_code", int'(fault_code), 1);
    check("enc_src", int'(fault_src), 0);
    check("enc_cnt1", int'(fault_cnt), 1);
    for (int k = 0; k < 18; k++) tick();
    check("cnt_saturated", int'(fault_cnt), 15);

    // Reset in the middle of a fault, then a first sample of yellow.
    rst = 1'b1;
    tick();
    check("midreset_fault", int'(fault), 0);
    check("midreset_code", int'(fault_code), 0);
    check("midreset_src", int'(fault_src), 0);
    check("midreset_cnt", int'(fault_cnt), 0);
    rst = 1'b0;
    set_lamps({Y, R, R, R});
    tick();
    check("post_reset_fault", int'(fault), 0);
    check("post_reset_cnt", int'(fault_cnt), 0);
    tick();
    check("first_yel_no_seq", int'(fault), 0);
    tick();
    m1 = R;
    tick();
    tick();
    check("yel_then_red_clean", int'(fault), 0);
    check("yel_then_red_cnt", int'(fault_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
